// File: rtl/alt_vipitc121_sync_timing_gen_pkg.sv
// Shared types for the CVO sync timing generator and its Avalon-MM control slave:
// config-handshake state encoding and the timing configuration record.
package alt_vipitc121_sync_timing_gen_pkg;

  localparam int SYNC_WORD_LENGTH = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } sync_cfg_state_e;

  typedef struct packed {
    logic [SYNC_WORD_LENGTH-1:0] h_max;
    logic [SYNC_WORD_LENGTH-1:0] v_max;
    logic [SYNC_WORD_LENGTH-1:0] h_sync_start;
    logic [SYNC_WORD_LENGTH-1:0] h_sync_end;
    logic [SYNC_WORD_LENGTH-1:0] h_act_start;
    logic [SYNC_WORD_LENGTH-1:0] v_sync_start;
    logic [SYNC_WORD_LENGTH-1:0] v_sync_end;
    logic [SYNC_WORD_LENGTH-1:0] v_act_start;
    logic                        h_pol;
    logic                        v_pol;
  } sync_cfg_t;

  // Power-up timing: only the totals are meaningful, every compare point is zero.
  function automatic sync_cfg_t sync_cfg_defaults(input logic [SYNC_WORD_LENGTH-1:0] h_max,
                                                  input logic [SYNC_WORD_LENGTH-1:0] v_max);
    sync_cfg_t c;
    c       = '0;
    c.h_max = h_max;
    c.v_max = v_max;
    return c;
  endfunction

endpackage

// File: rtl/alt_vipitc121_sync_timing_gen_if.sv
// Counter/config/sync bundle between the generic counters, the control slave and
// the sync timing generator. slave = the timing generator side.
interface alt_vipitc121_sync_timing_gen_if
  import alt_vipitc121_sync_timing_gen_pkg::*;
#(
  parameter int WORD_LENGTH = SYNC_WORD_LENGTH
);
  logic                   enable;
  logic [WORD_LENGTH-1:0] h_count;
  logic [WORD_LENGTH-1:0] v_count;
  logic                   h_enable_count;
  logic                   start_count;
  logic [WORD_LENGTH-1:0] cfg_h_max;
  logic [WORD_LENGTH-1:0] cfg_v_max;
  logic [WORD_LENGTH-1:0] cfg_h_sync_start;
  logic [WORD_LENGTH-1:0] cfg_h_sync_end;
  logic [WORD_LENGTH-1:0] cfg_h_act_start;
  logic [WORD_LENGTH-1:0] cfg_v_sync_start;
  logic [WORD_LENGTH-1:0] cfg_v_sync_end;
  logic [WORD_LENGTH-1:0] cfg_v_act_start;
  logic                   cfg_h_pol;
  logic                   cfg_v_pol;
  logic                   cfg_update;
  logic                   cfg_ack;
  logic [WORD_LENGTH-1:0] h_max;
  logic [WORD_LENGTH-1:0] v_max;
  logic                   hsync;
  logic                   vsync;
  logic                   de;
  logic                   h_blank;
  logic                   v_blank;
  logic                   sol;
  logic                   sof;

  modport slave (
    input  enable, h_count, v_count, h_enable_count, start_count,
           cfg_h_max, cfg_v_max, cfg_h_sync_start, cfg_h_sync_end, cfg_h_act_start,
           cfg_v_sync_start, cfg_v_sync_end, cfg_v_act_start, cfg_h_pol, cfg_v_pol,
           cfg_update,
    output cfg_ack, h_max, v_max, hsync, vsync, de, h_blank, v_blank, sol, sof
  );

  modport master (
    output enable, h_count, v_count, h_enable_count, start_count,
           cfg_h_max, cfg_v_max, cfg_h_sync_start, cfg_h_sync_end, cfg_h_act_start,
           cfg_v_sync_start, cfg_v_sync_end, cfg_v_act_start, cfg_h_pol, cfg_v_pol,
           cfg_update,
    input  cfg_ack, h_max, v_max, hsync, vsync, de, h_blank, v_blank, sol, sof
  );

endinterface

// File: rtl/alt_vipitc121_sync_region_cmp.sv
// Per-axis region decode: sync window [start, end) and active region [act_start, max].
// Compare points beyond the axis total never fire, so a stale count cannot leak through.
module alt_vipitc121_sync_region_cmp
  import alt_vipitc121_sync_timing_gen_pkg::*;
#(
  parameter int WORD_LENGTH = SYNC_WORD_LENGTH
) (
  input  logic [WORD_LENGTH-1:0] i_count,
  input  logic [WORD_LENGTH-1:0] i_sync_start,
  input  logic [WORD_LENGTH-1:0] i_sync_end,
  input  logic [WORD_LENGTH-1:0] i_act_start,
  input  logic [WORD_LENGTH-1:0] i_max,
  output logic                   o_sync,
  output logic                   o_act
);

  logic w_sync_valid;
  logic w_act_valid;

  assign w_sync_valid = (i_sync_start <= i_max);
  assign w_act_valid  = (i_act_start <= i_max);

  assign o_sync = w_sync_valid && (i_count >= i_sync_start) && (i_count < i_sync_end);
  assign o_act  = w_act_valid && (i_count >= i_act_start);

endmodule

// File: rtl/alt_vipitc121_sync_timing_gen.sv
// Sync timing generator: decodes h/v counts into registered syncs/DE/blanking/strobes and
// applies double-buffered timing config only at a frame boundary (or while stopped).
module alt_vipitc121_sync_timing_gen
  import alt_vipitc121_sync_timing_gen_pkg::*;
#(
  parameter int WORD_LENGTH   = SYNC_WORD_LENGTH,
  parameter int H_MAX_DEFAULT = 1649,
  parameter int V_MAX_DEFAULT = 749
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  alt_vipitc121_sync_timing_gen_if.slave         bus
);

  localparam logic [WORD_LENGTH-1:0] L_H_MAX = WORD_LENGTH'(H_MAX_DEFAULT);
  localparam logic [WORD_LENGTH-1:0] L_V_MAX = WORD_LENGTH'(V_MAX_DEFAULT);
  localparam sync_cfg_t              L_CFG_RESET = sync_cfg_defaults(L_H_MAX, L_V_MAX);

  sync_cfg_state_e r_state;
  sync_cfg_t       r_staging;
  sync_cfg_t       r_shadow;
  logic            r_cfg_ack;

  sync_cfg_t       w_cfg_in;
  logic            w_frame_end;
  logic            w_sol;

  logic [WORD_LENGTH-1:0] w_axis_count     [2];
  logic [WORD_LENGTH-1:0] w_axis_sync_start[2];
  logic [WORD_LENGTH-1:0] w_axis_sync_end  [2];
  logic [WORD_LENGTH-1:0] w_axis_act_start [2];
  logic [WORD_LENGTH-1:0] w_axis_max       [2];
  logic                   w_axis_sync      [2];
  logic                   w_axis_act       [2];

  logic r_hsync, r_vsync, r_de, r_h_blank, r_v_blank, r_sol, r_sof;

  assign w_cfg_in = '{
    h_max:        bus.cfg_h_max,
    v_max:        bus.cfg_v_max,
    h_sync_start: bus.cfg_h_sync_start,
    h_sync_end:   bus.cfg_h_sync_end,
    h_act_start:  bus.cfg_h_act_start,
    v_sync_start: bus.cfg_v_sync_start,
    v_sync_end:   bus.cfg_v_sync_end,
    v_act_start:  bus.cfg_v_act_start,
    h_pol:        bus.cfg_h_pol,
    v_pol:        bus.cfg_v_pol
  };

  assign w_frame_end = bus.h_enable_count && (bus.h_count == r_shadow.h_max) &&
                       (bus.v_count == r_shadow.v_max);

  // Staging holds the latest request; a request coinciding with the boundary wins over it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_staging <= L_CFG_RESET;
      r_shadow  <= L_CFG_RESET;
      r_cfg_ack <= 1'b0;
    end else begin
      r_cfg_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.cfg_update) begin
            r_staging <= w_cfg_in;
            r_state   <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (bus.cfg_update) begin
            r_staging <= w_cfg_in;
          end
          if (w_frame_end || !bus.enable) begin
            r_shadow  <= bus.cfg_update ? w_cfg_in : r_staging;
            r_cfg_ack <= 1'b1;
            r_state   <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          if (bus.cfg_update) begin
            r_staging <= w_cfg_in;
            r_state   <= ST_PENDING;
          end else begin
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_axis_count[0]      = bus.h_count;
  assign w_axis_sync_start[0] = r_shadow.h_sync_start;
  assign w_axis_sync_end[0]   = r_shadow.h_sync_end;
  assign w_axis_act_start[0]  = r_shadow.h_act_start;
  assign w_axis_max[0]        = r_shadow.h_max;
  assign w_axis_count[1]      = bus.v_count;
  assign w_axis_sync_start[1] = r_shadow.v_sync_start;
  assign w_axis_sync_end[1]   = r_shadow.v_sync_end;
  assign w_axis_act_start[1]  = r_shadow.v_act_start;
  assign w_axis_max[1]        = r_shadow.v_max;

  // Axis 0 = horizontal, axis 1 = vertical.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      alt_vipitc121_sync_region_cmp #(
        .WORD_LENGTH (WORD_LENGTH)
      ) u_cmp (
        .i_count      (w_axis_count[gi]),
        .i_sync_start (w_axis_sync_start[gi]),
        .i_sync_end   (w_axis_sync_end[gi]),
        .i_act_start  (w_axis_act_start[gi]),
        .i_max        (w_axis_max[gi]),
        .o_sync       (w_axis_sync[gi]),
        .o_act        (w_axis_act[gi])
      );
    end
  endgenerate

  assign w_sol = (bus.h_count == '0) && bus.start_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hsync   <= 1'b0;
      r_vsync   <= 1'b0;
      r_de      <= 1'b0;
      r_h_blank <= 1'b0;
      r_v_blank <= 1'b0;
      r_sol     <= 1'b0;
      r_sof     <= 1'b0;
    end else if (!bus.enable) begin
      // Stopped: blank everything and park the syncs at their inactive level.
      r_hsync   <= r_shadow.h_pol;
      r_vsync   <= r_shadow.v_pol;
      r_de      <= 1'b0;
      r_h_blank <= 1'b1;
      r_v_blank <= 1'b1;
      r_sol     <= 1'b0;
      r_sof     <= 1'b0;
    end else begin
      r_hsync   <= w_axis_sync[0] ^ r_shadow.h_pol;
      r_vsync   <= w_axis_sync[1] ^ r_shadow.v_pol;
      r_de      <= w_axis_act[0] && w_axis_act[1];
      r_h_blank <= !w_axis_act[0];
      r_v_blank <= !w_axis_act[1];
      r_sol     <= w_sol;
      r_sof     <= w_sol && (bus.v_count == '0);
    end
  end

  assign bus.h_max   = r_shadow.h_max;
  assign bus.v_max   = r_shadow.v_max;
  assign bus.cfg_ack = r_cfg_ack;
  assign bus.hsync   = r_hsync;
  assign bus.vsync   = r_vsync;
  assign bus.de      = r_de;
  assign bus.h_blank = r_h_blank;
  assign bus.v_blank = r_v_blank;
  assign bus.sol     = r_sol;
  assign bus.sof     = r_sof;

endmodule

// File: tb/tb_alt_vipitc121_sync_timing_gen.sv
// Bench: the bench plays the h/v counters, keeps a frame-level model of the timing
// rules and config handshake, and compares every DUT output after every clock edge.
module tb_alt_vipitc121_sync_timing_gen;

  typedef struct {
    int hmax, vmax, hss, hse, has, vss, vse, vas, hpol, vpol;
  } tcfg_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alt_vipitc121_sync_timing_gen_if #(.WORD_LENGTH(12)) bus ();

  alt_vipitc121_sync_timing_gen #(
    .WORD_LENGTH   (12),
    .H_MAX_DEFAULT (1649),
    .V_MAX_DEFAULT (749)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // model state
  tcfg_t m_live, m_staged;
  bit    m_wait;
  int    e_hs, e_vs, e_de, e_hb, e_vb, e_sol, e_sof, e_ack;
  // external counter state
  int    cnt_h, cnt_v, phase, ticks;
  // running totals of DUT pulses, for window counts
  int    tot_sof, tot_sol, tot_hs, tot_de, tot_ack;
  int    d_sof, d_sol, d_hs, d_de, d_ack;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic tcfg_t cfg_from_bus();
    tcfg_t c;
    c.hmax = int'(bus.cfg_h_max);        c.vmax = int'(bus.cfg_v_max);
    c.hss  = int'(bus.cfg_h_sync_start); c.hse  = int'(bus.cfg_h_sync_end);
    c.has  = int'(bus.cfg_h_act_start);  c.vss  = int'(bus.cfg_v_sync_start);
    c.vse  = int'(bus.cfg_v_sync_end);   c.vas  = int'(bus.cfg_v_act_start);
    c.hpol = int'(bus.cfg_h_pol);        c.vpol = int'(bus.cfg_v_pol);
    return c;
  endfunction

  task automatic set_cfg(input int hmax, input int vmax, input int hss, input int hse,
                         input int has, input int vss, input int vse, input int vas,
                         input int hpol, input int vpol);
    bus.cfg_h_max = 12'(hmax);        bus.cfg_v_max = 12'(vmax);
    bus.cfg_h_sync_start = 12'(hss);  bus.cfg_h_sync_end = 12'(hse);
    bus.cfg_h_act_start = 12'(has);   bus.cfg_v_sync_start = 12'(vss);
    bus.cfg_v_sync_end = 12'(vse);    bus.cfg_v_act_start = 12'(vas);
    bus.cfg_h_pol = 1'(hpol);         bus.cfg_v_pol = 1'(vpol);
  endtask

  task automatic model_reset();
    m_live = '{hmax: 1649, vmax: 749, hss: 0, hse: 0, has: 0, vss: 0, vse: 0, vas: 0,
               hpol: 0, vpol: 0};
    m_staged = m_live;
    m_wait = 0;
    e_hs = 0; e_vs = 0; e_de = 0; e_hb = 0; e_vb = 0; e_sol = 0; e_sof = 0; e_ack = 0;
  endtask

  // Evaluate one rising edge from the inputs the DUT saw at that edge.
  task automatic model_edge();
    int h, v, hon, von, hact, vact;
    bit fe, apply, en, upd;
    tcfg_t in;
    h = int'(bus.h_count); v = int'(bus.v_count);
    en = bus.enable; upd = bus.cfg_update; in = cfg_from_bus();
    // counters wrap on the totals that were live before this edge
    if (!en) begin
      cnt_h = 0; cnt_v = 0; phase = 0;
    end else begin
      if (bus.h_enable_count) begin
        if (cnt_h >= m_live.hmax) begin
          cnt_h = 0;
          cnt_v = (cnt_v >= m_live.vmax) ? 0 : cnt_v + 1;
        end else cnt_h = cnt_h + 1;
      end
      if (ticks == 2) phase = 1 - phase;
    end
    if (reset_n) begin
      if (!en) begin
        e_hs = m_live.hpol; e_vs = m_live.vpol; e_de = 0; e_hb = 1; e_vb = 1;
        e_sol = 0; e_sof = 0;
      end else begin
        hon  = (h >= m_live.hss && h < m_live.hse && m_live.hss <= m_live.hmax) ? 1 : 0;
        von  = (v >= m_live.vss && v < m_live.vse && m_live.vss <= m_live.vmax) ? 1 : 0;
        hact = (h >= m_live.has && m_live.has <= m_live.hmax) ? 1 : 0;
        vact = (v >= m_live.vas && m_live.vas <= m_live.vmax) ? 1 : 0;
        e_hs = hon ^ m_live.hpol; e_vs = von ^ m_live.vpol;
        e_de = hact & vact; e_hb = 1 - hact; e_vb = 1 - vact;
        e_sol = (h == 0 && bus.start_count) ? 1 : 0;
        e_sof = (e_sol == 1 && v == 0) ? 1 : 0;
      end
      fe = bus.h_enable_count && h == m_live.hmax && v == m_live.vmax;
      apply = m_wait && (fe || !en);
      e_ack = apply ? 1 : 0;
      if (apply) begin
        m_live = upd ? in : m_staged;
        m_wait = 0;
      end else if (upd) begin
        m_staged = in;
        m_wait = 1;
      end
    end
  endtask

  task automatic drive_next();
    bus.h_count        = 12'(cnt_h);
    bus.v_count        = 12'(cnt_v);
    bus.start_count    = (ticks == 1) || (phase == 0);
    bus.h_enable_count = (ticks == 1) || (phase == 1);
    bus.cfg_update     = 1'b0;
  endtask

  task automatic compare_all();
    chk("hsync",   int'(bus.hsync),   e_hs);
    chk("vsync",   int'(bus.vsync),   e_vs);
    chk("de",      int'(bus.de),      e_de);
    chk("h_blank", int'(bus.h_blank), e_hb);
    chk("v_blank", int'(bus.v_blank), e_vb);
    chk("sol",     int'(bus.sol),     e_sol);
    chk("sof",     int'(bus.sof),     e_sof);
    chk("cfg_ack", int'(bus.cfg_ack), e_ack);
    chk("h_max",   int'(bus.h_max),   m_live.hmax);
    chk("v_max",   int'(bus.v_max),   m_live.vmax);
    tot_sof += int'(bus.sof); tot_sol += int'(bus.sol); tot_hs += int'(bus.hsync);
    tot_de  += int'(bus.de);  tot_ack += int'(bus.cfg_ack);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    drive_next();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_window(input int n);
    int s_sof, s_sol, s_hs, s_de, s_ack;
    s_sof = tot_sof; s_sol = tot_sol; s_hs = tot_hs; s_de = tot_de; s_ack = tot_ack;
    repeat (n) step();
    d_sof = tot_sof - s_sof; d_sol = tot_sol - s_sol; d_hs = tot_hs - s_hs;
    d_de  = tot_de - s_de;   d_ack = tot_ack - s_ack;
    $display("window %0d cycles: sof=%0d sol=%0d hsync=%0d de=%0d ack=%0d",
             n, d_sof, d_sol, d_hs, d_de, d_ack);
  endtask

  task automatic pulse_update();
    bus.cfg_update = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.enable = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ticks = 1; cnt_h = 0; cnt_v = 0; phase = 0;
    tot_sof = 0; tot_sol = 0; tot_hs = 0; tot_de = 0; tot_ack = 0;
    model_reset();
    drive_next();

    // reset defaults
    repeat (3) step();
    chk("reset_h_max", int'(bus.h_max), 1649);
    chk("reset_v_max", int'(bus.v_max), 749);
    chk("reset_de", int'(bus.de), 0);
    chk("reset_ack", int'(bus.cfg_ack), 0);
    reset_n = 1'b1;
    bus.enable = 1'b1;
    repeat (20) step();
    chk("default_de_on", int'(bus.de), 1);
    // mid-run reset is asynchronous
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_de", int'(bus.de), 0);
    chk("midrst_h_max", int'(bus.h_max), 1649);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (5) step();

    // small timing applied while stopped
    bus.enable = 1'b0;
    set_cfg(9, 4, 1, 3, 5, 0, 1, 2, 0, 0);
    pulse_update();
    run_window(4);
    chk("small_ack_cnt", d_ack, 1);
    chk("small_h_max", int'(bus.h_max), 9);
    chk("small_v_max", int'(bus.v_max), 4);
    bus.enable = 1'b1;
    run_window(100);
    chk("small_sof_cnt", d_sof, 2);
    chk("small_hsync_cnt", d_hs, 20);
    chk("small_de_cnt", d_de, 30);

    // mid-frame request waits for the frame boundary
    repeat (13) step();
    set_cfg(7, 4, 1, 3, 5, 0, 1, 2, 0, 0);
    pulse_update();
    repeat (2) step();
    chk("bnd_h_max_before", int'(bus.h_max), 9);
    run_window(60);
    chk("bnd_ack_cnt", d_ack, 1);
    chk("bnd_h_max_after", int'(bus.h_max), 7);

    // back-to-back requests: only the later one lands
    set_cfg(7, 4, 1, 3, 5, 0, 1, 2, 0, 0);
    pulse_update();
    repeat (2) step();
    set_cfg(7, 4, 1, 4, 5, 0, 1, 2, 0, 0);
    pulse_update();
    run_window(80);
    chk("b2b_ack_cnt", d_ack, 1);
    run_window(40);
    chk("b2b_hsync_cnt", d_hs, 15);

    // inverted polarity, empty sync window, active start beyond total
    bus.enable = 1'b0;
    set_cfg(7, 4, 2, 2, 12, 0, 1, 2, 1, 0);
    pulse_update();
    run_window(4);
    chk("pol_ack_cnt", d_ack, 1);
    bus.enable = 1'b1;
    run_window(40);
    chk("pol_hsync_cnt", d_hs, 40);
    chk("pol_de_cnt", d_de, 0);

    // two ticks per count
    bus.enable = 1'b0;
    set_cfg(7, 4, 1, 3, 5, 0, 1, 2, 0, 0);
    pulse_update();
    run_window(4);
    chk("t2_cfg_ack_cnt", d_ack, 1);
    ticks = 2;
    drive_next();
    bus.enable = 1'b1;
    run_window(80);
    chk("t2_sof_cnt", d_sof, 1);
    chk("t2_sol_cnt", d_sol, 5);
    chk("t2_hsync_cnt", d_hs, 20);
    chk("t2_de_cnt", d_de, 18);
    set_cfg(9, 4, 1, 3, 5, 0, 1, 2, 0, 0);
    pulse_update();
    run_window(100);
    chk("t2_bnd_ack_cnt", d_ack, 1);
    chk("t2_h_max_after", int'(bus.h_max), 9);

    // reset while a request is pending discards it
    set_cfg(5, 4, 1, 3, 5, 0, 1, 2, 0, 0);
    pulse_update();
    step();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("pendrst_h_max", int'(bus.h_max), 1649);
    chk("pendrst_v_max", int'(bus.v_max), 749);
    chk("pendrst_ack", int'(bus.cfg_ack), 0);
    repeat (3) step();
    reset_n = 1'b1;
    ticks = 1;
    drive_next();
    run_window(60);
    chk("pendrst_ack_cnt", d_ack, 0);
    chk("pendrst_h_max_after", int'(bus.h_max), 1649);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
